// File: rtl/sync_req_arbiter.sv
// Round-robin arbiter sharing one resource between NUM_REQ asynchronous request lines.
// Define SYNC_ARB_TIMEOUT_EN to add a grant watchdog that aborts after TIMEOUT_CYCLES.
module sync_req_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int ID_W           = 2,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic               clk,
    input  logic               n_reset,
    input  logic [NUM_REQ-1:0] async_req,
    input  logic               done,
    output logic [NUM_REQ-1:0] grant,
    output logic               grant_valid,
    output logic [ID_W-1:0]    grant_id,
    output logic [NUM_REQ-1:0] pending,
    output logic               timeout
);

    if (NUM_REQ < 2 || NUM_REQ > 16 || ID_W != $clog2(NUM_REQ) || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
        $error("sync_req_arbiter: illegal parameter combination");
    end

    typedef enum logic {IDLE, GRANT} state_t;

    state_t             state;
    logic [NUM_REQ-1:0] s1, s2, prev, rise;
    logic [NUM_REQ-1:0] sel_onehot, clr;
    logic [ID_W-1:0]    rr_ptr, sel, idx;
    logic               found;
    logic               expire;

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            s1   <= '0;
            s2   <= '0;
            prev <= '0;
        end else begin
            s1   <= async_req;
            s2   <= s1;
            prev <= s2;
        end
    end

    assign rise = s2 & ~prev;

    // First pending channel after rr_ptr, wrapping modulo NUM_REQ.
    always_comb begin
        sel   = rr_ptr;
        found = 1'b0;
        idx   = '0;
        for (int unsigned k = 1; k <= NUM_REQ; k++) begin
            idx = ID_W'((32'(rr_ptr) + k) % NUM_REQ);
            if (!found && pending[idx]) begin
                sel   = idx;
                found = 1'b1;
            end
        end
    end

    assign sel_onehot = {{(NUM_REQ-1){1'b0}}, 1'b1} << sel;
    assign clr        = (state == IDLE) ? (sel_onehot & {NUM_REQ{found}}) : '0;

    // A rise on the granting edge wins over the clear.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            pending <= '0;
        end else begin
            pending <= (pending & ~clr) | rise;
        end
    end

`ifdef SYNC_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] cnt;

    assign expire = (state == GRANT) && !done && (cnt == CNT_LAST);

    // Counter idles at zero, so it is already clear on entry to GRANT.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            cnt     <= '0;
            timeout <= 1'b0;
        end else begin
            timeout <= expire;
            if (state == IDLE) begin
                cnt <= '0;
            end else if (!done && !expire) begin
                cnt <= cnt + 1'b1;
            end
        end
    end
`else
    assign expire  = 1'b0;
    assign timeout = 1'b0;
`endif

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state    <= IDLE;
            grant    <= '0;
            grant_id <= '0;
            rr_ptr   <= ID_W'(NUM_REQ - 1);
        end else begin
            case (state)
                IDLE: begin
                    if (found) begin
                        grant    <= sel_onehot;
                        grant_id <= sel;
                        rr_ptr   <= sel;
                        state    <= GRANT;
                    end
                end
                GRANT: begin
                    if (done || expire) begin
                        grant    <= '0;
                        grant_id <= '0;
                        state    <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign grant_valid = |grant;

endmodule

// File: tb/tb_sync_req_arbiter.sv
// Self-checking bench for sync_req_arbiter: vector table, hand sequences, random vs model.
module tb_sync_req_arbiter;
    localparam int N  = 4;
    localparam int TO = 8;
`ifdef SYNC_ARB_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic         clk;
    logic         n_reset;
    logic [N-1:0] async_req;
    logic         done;
    logic [N-1:0] grant;
    logic         grant_valid;
    logic [1:0]   grant_id;
    logic [N-1:0] pending;
    logic         timeout;

    sync_req_arbiter #(.NUM_REQ(N), .ID_W(2), .TIMEOUT_CYCLES(TO)) dut (
        .clk         (clk),
        .n_reset     (n_reset),
        .async_req   (async_req),
        .done        (done),
        .grant       (grant),
        .grant_valid (grant_valid),
        .grant_id    (grant_id),
        .pending     (pending),
        .timeout     (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        n_reset   = 1'b0;
        async_req = '0;
        done      = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_reset = 1'b1;
    endtask

    typedef struct {
        logic         n_rst;
        logic [N-1:0] req;
        logic         dn;
        logic [N-1:0] g;
        logic [1:0]   id;
        logic [N-1:0] p;
    } vec_t;

    vec_t vq[$];

    task automatic add(input logic r, input logic [N-1:0] q, input logic d,
                       input logic [N-1:0] g, input logic [1:0] id, input logic [N-1:0] p);
        vec_t v;
        v.n_rst = r; v.req = q; v.dn = d; v.g = g; v.id = id; v.p = p;
        vq.push_back(v);
    endtask

    // Reference model: integer owner/last-granted bookkeeping and a queue of input samples.
    logic [N-1:0] m_pend;
    int           m_owner;
    int           m_last;
    int           m_held;
    logic         m_to;
    logic [N-1:0] smp[$];

    task automatic model_reset();
        m_pend  = '0;
        m_owner = -1;
        m_last  = N - 1;
        m_held  = 0;
        m_to    = 1'b0;
        smp     = {4'b0, 4'b0, 4'b0};
    endtask

    task automatic model_edge(input logic [N-1:0] req, input logic dn);
        logic [N-1:0] r;
        bit           hit;
        int           c;
        r    = smp[1] & ~smp[2];
        m_to = 1'b0;
        hit  = 1'b0;
        if (m_owner < 0) begin
            for (int k = 1; k <= N; k++) begin
                c = (m_last + k) % N;
                if (!hit && m_pend[c]) begin
                    hit       = 1'b1;
                    m_owner   = c;
                    m_last    = c;
                    m_pend[c] = 1'b0;
                    m_held    = 0;
                end
            end
        end else if (dn) begin
            m_owner = -1;
        end else if (TO_EN && (m_held + 1 == TO)) begin
            m_owner = -1;
            m_to    = 1'b1;
        end else begin
            m_held++;
        end
        m_pend = m_pend | r;
        smp.push_front(req);
        void'(smp.pop_back());
    endtask

    initial begin
        logic [N-1:0] eg;
        logic [1:0]   eid;
        vec_t         v;

        n_reset = 1'b0; async_req = '0; done = 1'b0;

        // Reset then idle
        repeat (3) @(posedge clk);
        #1;
        check("reset_state", {grant, grant_valid, grant_id, pending, timeout}, '0);
        @(negedge clk);
        n_reset = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            check($sformatf("idle[%0d]", i), {grant, grant_valid, grant_id, pending, timeout}, '0);
        end

        // Vector table: single request latency, reset, round-robin
        add(1, 4'b0000, 0, 4'b0000, 0, 4'b0000);
        add(1, 4'b0000, 0, 4'b0000, 0, 4'b0000);
        add(1, 4'b0100, 0, 4'b0000, 0, 4'b0000);
        add(1, 4'b0100, 0, 4'b0000, 0, 4'b0000);
        add(1, 4'b0100, 0, 4'b0000, 0, 4'b0100);
        add(1, 4'b0100, 0, 4'b0100, 2, 4'b0000);
        add(1, 4'b0100, 0, 4'b0100, 2, 4'b0000);
        add(1, 4'b0100, 1, 4'b0000, 0, 4'b0000);
        add(1, 4'b0100, 1, 4'b0000, 0, 4'b0000);
        add(1, 4'b0000, 0, 4'b0000, 0, 4'b0000);
        add(0, 4'b0000, 0, 4'b0000, 0, 4'b0000);
        add(1, 4'b1111, 0, 4'b0000, 0, 4'b0000);
        add(1, 4'b1111, 0, 4'b0000, 0, 4'b0000);
        add(1, 4'b1111, 1, 4'b0000, 0, 4'b1111);
        add(1, 4'b1111, 0, 4'b0001, 0, 4'b1110);
        add(1, 4'b1111, 1, 4'b0000, 0, 4'b1110);
        add(1, 4'b1111, 0, 4'b0010, 1, 4'b1100);
        add(1, 4'b1111, 1, 4'b0000, 0, 4'b1100);
        add(1, 4'b1111, 0, 4'b0100, 2, 4'b1000);
        add(1, 4'b1111, 1, 4'b0000, 0, 4'b1000);
        add(1, 4'b1111, 0, 4'b1000, 3, 4'b0000);
        add(1, 4'b1111, 1, 4'b0000, 0, 4'b0000);
        add(1, 4'b1111, 0, 4'b0000, 0, 4'b0000);
        for (int i = 0; i < vq.size(); i++) begin
            v = vq[i];
            n_reset = v.n_rst; async_req = v.req; done = v.dn;
            tick();
            check($sformatf("vec[%0d].grant", i), grant, v.g);
            check($sformatf("vec[%0d].grant_id", i), grant_id, v.id);
            check($sformatf("vec[%0d].pending", i), pending, v.p);
            check($sformatf("vec[%0d].grant_valid", i), grant_valid, |v.g);
        end

        // Set/clear collision on channel 1, with channel 2 ahead in rotation
        do_reset();
        async_req = 4'b0001; tick();
        async_req = 4'b0111; tick();
        async_req = 4'b0101; tick();
        tick();
        check("coll_e4", {grant, grant_id, pending}, {4'b0001, 2'd0, 4'b0110});
        tick(); tick();
        async_req = 4'b0111; tick();
        done = 1'b1; tick();
        check("coll_e8", {grant, pending}, {4'b0000, 4'b0110});
        done = 1'b0; tick();
        check("coll_e9", {grant, grant_id, pending}, {4'b0010, 2'd1, 4'b0110});
        done = 1'b1; tick();
        done = 1'b0; tick();
        check("coll_e11", {grant, grant_id, pending}, {4'b0100, 2'd2, 4'b0010});
        done = 1'b1; tick();
        done = 1'b0; tick();
        check("coll_e13", {grant, grant_id, pending}, {4'b0010, 2'd1, 4'b0000});
        done = 1'b1; tick();
        check("coll_e14", {grant, grant_valid}, '0);
        done = 1'b0;

        // Reset mid-grant, then re-request from the still-high line
        do_reset();
        async_req = 4'b0001;
        repeat (4) tick();
        check("midrst_grant", grant, 4'b0001);
        #2 n_reset = 1'b0;
        #1;
        check("midrst_async_drop", {grant, grant_valid, grant_id, pending}, '0);
        @(negedge clk);
        n_reset = 1'b1;
        repeat (3) tick();
        check("midrst_e3", {grant, pending}, {4'b0000, 4'b0001});
        tick();
        check("midrst_e4", {grant, grant_id}, {4'b0001, 2'd0});

        // Watchdog behaviour on channel 3
        do_reset();
        async_req = 4'b1000;
        repeat (4) tick();
        check("to_grant", {grant, grant_id}, {4'b1000, 2'd3});
        if (TO_EN) begin
            repeat (TO - 1) tick();
            check("to_last_hold", {grant, timeout}, {4'b1000, 1'b0});
            tick();
            check("to_abort", {grant, timeout, pending}, {4'b0000, 1'b1, 4'b0000});
            tick();
            check("to_pulse_end", {grant, timeout, pending}, {4'b0000, 1'b0, 4'b0000});
        end else begin
            for (int i = 0; i < 100; i++) begin
                tick();
                check($sformatf("hold[%0d]", i), {grant, timeout}, {4'b1000, 1'b0});
            end
        end

        // Randomized traffic against the reference model
        do_reset();
        model_reset();
        for (int i = 0; i < 600; i++) begin
            for (int b = 0; b < N; b++) begin
                if ($urandom_range(0, 3) == 0) async_req[b] = ~async_req[b];
            end
            done = ($urandom_range(0, 2) == 0);
            @(posedge clk);
            model_edge(async_req, done);
            #1;
            eg  = (m_owner >= 0) ? 4'(1 << m_owner) : 4'b0000;
            eid = (m_owner >= 0) ? 2'(m_owner) : 2'd0;
            check($sformatf("rand[%0d]", i), {grant, grant_valid, grant_id, pending, timeout},
                  {eg, |eg, eid, m_pend, m_to});
            check($sformatf("onehot[%0d]", i), 32'($onehot0(grant)), 32'd1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule
